// File: rtl/bus_write_demux_if.sv
// CPU-request / slave-strobe bundle for bus_write_demux.
// The demux takes the slave modport; the CPU and slave models take the master modport.
interface bus_write_demux_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_err;
  logic [2:0]  rsp_sel;
  logic [5:0]  s_valid;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [5:0]  s_ack;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, s_ack,
    input  req_ready, rsp_valid, rsp_err, rsp_sel,
           s_valid, s_we, s_addr, s_wdata, s_be
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, s_ack,
    output req_ready, rsp_valid, rsp_err, rsp_sel,
           s_valid, s_we, s_addr, s_wdata, s_be
  );
endinterface

// File: rtl/bus_write_demux.sv
// Address-decoding request demux from the OTTER memory stage to up to six slaves.
// Define BUS_DEMUX_TIMEOUT_EN to abort a BUSY transfer after TIMEOUT cycles without an ack.
module bus_write_demux #(
  parameter int N_PORTS = 6,
  parameter int SEL_LO  = 28,
  parameter int TIMEOUT = 16
) (
  input logic               CLK,
  input logic               RST_N,
  bus_write_demux_if.slave  bus
);

  if (N_PORTS < 1 || N_PORTS > 6 || SEL_LO < 0 || SEL_LO > 29 ||
      TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("bus_write_demux: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [2:0] dec_idx;
  logic       dec_hit;
  logic       ack_hit;
`ifdef BUS_DEMUX_TIMEOUT_EN
  logic [7:0] cnt;
`endif

  assign dec_idx       = bus.req_addr[SEL_LO+2:SEL_LO];
  assign dec_hit       = ({1'b0, dec_idx} < 4'(N_PORTS));
  // s_valid is one-hot on idx while BUSY, so this sees only the addressed slave's ack
  assign ack_hit       = |(bus.s_ack & bus.s_valid);
  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      idx           <= 3'd0;
      bus.s_valid   <= 6'd0;
      bus.s_we      <= 1'b0;
      bus.s_addr    <= 32'd0;
      bus.s_wdata   <= 32'd0;
      bus.s_be      <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_sel   <= 3'd0;
`ifdef BUS_DEMUX_TIMEOUT_EN
      cnt           <= 8'd0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.s_we    <= bus.req_we;
            bus.s_addr  <= bus.req_addr;
            bus.s_wdata <= bus.req_wdata;
            bus.s_be    <= bus.req_be;
            idx         <= dec_idx;
            if (dec_hit) begin
              bus.s_valid <= 6'b000001 << dec_idx;
              state       <= BUSY;
`ifdef BUS_DEMUX_TIMEOUT_EN
              cnt         <= 8'd0;
`endif
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          if (ack_hit) begin
            bus.s_valid   <= 6'd0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_sel   <= idx;
            state         <= IDLE;
          end
`ifdef BUS_DEMUX_TIMEOUT_EN
          // an ack in the expiry cycle takes the branch above, so it wins
          else if (cnt == 8'(TIMEOUT - 1)) begin
            bus.s_valid   <= 6'd0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_sel   <= idx;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        ERR: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b1;
          bus.rsp_sel   <= 3'd7;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_write_demux.sv
// Scoreboard bench for bus_write_demux: expected responses are queued at request time
// and popped when rsp_valid appears.
module tb_bus_write_demux;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  bus_write_demux_if bus ();

  bus_write_demux #(.N_PORTS(6), .SEL_LO(28), .TIMEOUT(16)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct packed {
    logic       err;
    logic [2:0] sel;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  // Waits (bounded) for rsp_valid, then pops the matching expectation.
  task automatic collect_rsp(output bit got, output rsp_t act, output rsp_t exp);
    got = 1'b0;
    act = '0;
    exp = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (got) begin
      act = {bus.rsp_err, bus.rsp_sel};
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else got = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.s_valid, bus.rsp_valid, bus.rsp_err, bus.rsp_sel} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got s_valid=%b rsp_valid=%b rsp_err=%b rsp_sel=%0d, want all 0",
               bus.s_valid, bus.rsp_valid, bus.rsp_err, bus.rsp_sel);
    end
    vectors++;
    if ({bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got we=%b addr=%h wdata=%h be=%h, want all 0",
               bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be);
    end
    RST_N = 1'b1;
    tick();
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    bit got;
    rsp_t act, exp;
    drive_req(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back('{err: 1'b0, sel: 3'd2});
    tick();
    bus.req_valid = 1'b0;
    vectors++;
    if ({bus.s_valid, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be} !==
        {6'b000100, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF}) begin
      miscompares++;
      $display("FAIL write_bus: got s_valid=%b we=%b addr=%h wdata=%h be=%h, want 000100 1 20000010 deadbeef f",
               bus.s_valid, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be);
    end
    vectors++;
    if (bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_busy_ready: got %b want 0", bus.req_ready);
    end
    tick();
    tick();
    vectors++;
    if ({bus.s_valid, bus.rsp_valid} !== {6'b000100, 1'b0}) begin
      miscompares++;
      $display("FAIL write_hold: got s_valid=%b rsp_valid=%b want 000100 0", bus.s_valid, bus.rsp_valid);
    end
    bus.s_ack = 6'b000100;
    tick();
    bus.s_ack = 6'd0;
    collect_rsp(got, act, exp);
    vectors++;
    if (!got || act !== exp) begin
      miscompares++;
      $display("FAIL write_rsp: got valid=%b err=%b sel=%0d, want err=%b sel=%0d",
               got, act.err, act.sel, exp.err, exp.sel);
    end
    vectors++;
    if ({bus.s_valid, bus.req_ready} !== {6'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL write_release: got s_valid=%b req_ready=%b want 000000 1", bus.s_valid, bus.req_ready);
    end
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_sel} !== {1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL write_one_cycle: got rsp_valid=%b rsp_sel=%0d want 0 2", bus.rsp_valid, bus.rsp_sel);
    end
  endtask

  task automatic test_decode_err();
    bit got;
    rsp_t act, exp;
    logic [31:0] addrs [2];
    addrs[0] = 32'h7000_0000;
    addrs[1] = 32'h6000_0000;
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b0, addrs[k], 32'h0, 4'h0);
      exp_q.push_back('{err: 1'b1, sel: 3'd7});
      tick();
      bus.req_valid = 1'b0;
      vectors++;
      if ({bus.s_valid, bus.req_ready, bus.rsp_valid} !== {6'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL decode_err_busy[%0d]: got s_valid=%b req_ready=%b rsp_valid=%b want 000000 0 0",
                 k, bus.s_valid, bus.req_ready, bus.rsp_valid);
      end
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL decode_err_latency[%0d]: got rsp_valid=%b want 1", k, bus.rsp_valid);
      end
      collect_rsp(got, act, exp);
      vectors++;
      if (!got || act !== exp || bus.s_valid !== 6'd0) begin
        miscompares++;
        $display("FAIL decode_err_rsp[%0d]: got valid=%b err=%b sel=%0d s_valid=%b, want err=%b sel=%0d",
                 k, got, act.err, act.sel, bus.s_valid, exp.err, exp.sel);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    rsp_t act, exp;
    drive_req(1'b0, 32'h0000_0100, 32'h0, 4'h3);
    exp_q.push_back('{err: 1'b0, sel: 3'd0});
    tick();
    bus.req_valid = 1'b0;
    bus.s_ack = 6'b000010;
    tick();
    tick();
    vectors++;
    if ({bus.s_valid, bus.rsp_valid} !== {6'b000001, 1'b0}) begin
      miscompares++;
      $display("FAIL ignored_ack: got s_valid=%b rsp_valid=%b want 000001 0", bus.s_valid, bus.rsp_valid);
    end
    bus.s_ack = 6'b000001;
    tick();
    bus.s_ack = 6'd0;
    collect_rsp(got, act, exp);
    vectors++;
    if (!got || act !== exp) begin
      miscompares++;
      $display("FAIL b2b_rsp0: got valid=%b err=%b sel=%0d, want err=%b sel=%0d",
               got, act.err, act.sel, exp.err, exp.sel);
    end
    drive_req(1'b1, 32'h5000_0004, 32'h1234_5678, 4'h1);
    exp_q.push_back('{err: 1'b0, sel: 3'd5});
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    vectors++;
    if ({bus.s_valid, bus.rsp_valid, bus.s_addr} !== {6'b100000, 1'b0, 32'h5000_0004}) begin
      miscompares++;
      $display("FAIL b2b_accept: got s_valid=%b rsp_valid=%b addr=%h want 100000 0 50000004",
               bus.s_valid, bus.rsp_valid, bus.s_addr);
    end
    bus.s_ack = 6'b100000;
    tick();
    bus.s_ack = 6'd0;
    collect_rsp(got, act, exp);
    vectors++;
    if (!got || act !== exp) begin
      miscompares++;
      $display("FAIL b2b_rsp5: got valid=%b err=%b sel=%0d, want err=%b sel=%0d",
               got, act.err, act.sel, exp.err, exp.sel);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit got;
    rsp_t act, exp;
    int n;
    drive_req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
    exp_q.push_back('{err: 1'b1, sel: 3'd3});
    n = 0;
    while (bus.s_valid === 6'b001000 && n < 40) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d busy cycles want 16", n);
    end
`else
    exp_q.push_back('{err: 1'b0, sel: 3'd3});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rsp_valid === 1'b1) n++;
      tick();
    end
    vectors++;
    if (bus.s_valid !== 6'b001000 || n != 0) begin
      miscompares++;
      $display("FAIL no_timeout_hold: got s_valid=%b responses=%0d want 001000 0", bus.s_valid, n);
    end
    bus.s_ack = 6'b001000;
    tick();
    bus.s_ack = 6'd0;
`endif
    collect_rsp(got, act, exp);
    vectors++;
    if (!got || act !== exp || bus.s_valid !== 6'd0) begin
      miscompares++;
      $display("FAIL timeout_rsp: got valid=%b err=%b sel=%0d s_valid=%b, want err=%b sel=%0d",
               got, act.err, act.sel, bus.s_valid, exp.err, exp.sel);
    end
    tick();
  endtask

  task automatic test_timeout_tie();
    bit got;
    rsp_t act, exp;
    drive_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    exp_q.push_back('{err: 1'b0, sel: 3'd4});
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if ({bus.s_valid, bus.rsp_valid} !== {6'b010000, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_pre: got s_valid=%b rsp_valid=%b want 010000 0", bus.s_valid, bus.rsp_valid);
    end
    bus.s_ack = 6'b010000;
    tick();
    bus.s_ack = 6'd0;
    collect_rsp(got, act, exp);
    vectors++;
    if (!got || act !== exp) begin
      miscompares++;
      $display("FAIL tie_rsp: got valid=%b err=%b sel=%0d, want err=%b sel=%0d",
               got, act.err, act.sel, exp.err, exp.sel);
    end
    tick();
  endtask

  task automatic test_reset_busy();
    int n;
    drive_req(1'b1, 32'h1000_0008, 32'hCAFE_F00D, 4'hC);
    tick();
    bus.req_valid = 1'b0;
    vectors++;
    if (bus.s_valid !== 6'b000010) begin
      miscompares++;
      $display("FAIL rstbusy_accept: got s_valid=%b want 000010", bus.s_valid);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    vectors++;
    if ({bus.s_valid, bus.rsp_valid, bus.rsp_err, bus.rsp_sel, bus.s_we, bus.s_addr,
         bus.s_wdata, bus.s_be} !== 80'd0) begin
      miscompares++;
      $display("FAIL rstbusy_zero: got s_valid=%b rsp_valid=%b sel=%0d addr=%h wdata=%h, want all 0",
               bus.s_valid, bus.rsp_valid, bus.rsp_sel, bus.s_addr, bus.s_wdata);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) n++;
    end
    vectors++;
    if (n != 0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstbusy_quiet: got responses=%0d req_ready=%b want 0 1", n, bus.req_ready);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_be    = 4'd0;
    bus.s_ack     = 6'd0;
    test_reset();
    test_write();
    test_decode_err();
    test_back_to_back();
    test_timeout();
    test_timeout_tie();
    test_reset_busy();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
